regfile_wb_arbiter: RTL



---
 rtl/wb_arb_pkg.sv | 17 +
 rtl/regfile_wb_arbiter_if.sv | 14 +
 rtl/wb_rr_picker.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 75 +++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Build option: WB_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
package wb_arb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_req_t;

    // Explicit modulo-n increment; NUM_REQ need not be a power of two.
    function automatic int wrap_inc(input int v, input int n);
        return (v >= n - 1) ? 0 : v + 1;
    endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: NUM_REQ valid/ready lanes with flattened addr/data.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;

    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/wb_rr_picker.sv
// Circular first-one picker: scans valid starting at start, wrapping at N.
import wb_arb_pkg::*;

module wb_rr_picker #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);
    int pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = int'(start);
        for (int k = 0; k < N; k++) begin
            if (!any && valid[pos]) begin
                any        = 1'b1;
                idx        = PW'(pos);
                grant[pos] = 1'b1;
            end
            pos = wrap_inc(pos, N);
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ requesters (round-robin,
// or fixed priority when WB_ARB_FIXED_PRIO_EN is defined); one-cycle latency.
import wb_arb_pkg::*;

module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_hold,
    regfile_wb_arbiter_if.slave bus,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   WriteRegister,
    output logic [DATA_W-1:0]   WriteData,
    output logic                wb_busy
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] valid_eff;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      start;
    logic [PW-1:0]      gidx;
    logic               xfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    // Hold and reset both mask requests so ready stays zero while either is high.
    assign valid_eff = (rst || wb_hold) ? '0 : bus.req_valid;

    wb_rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
        .valid (valid_eff),
        .start (start),
        .grant (grant),
        .idx   (gidx),
        .any   (xfer)
    );

    assign bus.req_ready = grant;
    assign sel_addr      = bus.req_addr[gidx*ADDR_W +: ADDR_W];
    assign sel_data      = bus.req_data[gidx*DATA_W +: DATA_W];

`ifdef WB_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [PW-1:0] rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (xfer)
            rr_ptr <= PW'(wrap_inc(int'(gidx), NUM_REQ));
    end

    assign start = rr_ptr;
`endif

    // x0 writes are accepted and latched but never enabled at the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else if (xfer) begin
            RegWrite      <= (sel_addr != '0);
            WriteRegister <= sel_addr;
            WriteData     <= sel_data;
        end else begin
            RegWrite      <= 1'b0;
        end
    end

    assign wb_busy = RegWrite;
endmodule
